// File: rtl/float_subtract_feeder_if.sv
// rtl/float_subtract_feeder_if.sv - label, dot-product and operand-pair signals of the subtract feeder
interface float_subtract_feeder_if;
  logic [31:0] label_in;
  logic        label_valid;
  logic        label_ready;
  logic [31:0] dot_in;
  logic        dot_valid;
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic        sub_valid;

  modport master (
    output label_in, label_valid, dot_in, dot_valid,
    input  label_ready, sub_a, sub_b, sub_valid
  );

  modport slave (
    input  label_in, label_valid, dot_in, dot_valid,
    output label_ready, sub_a, sub_b, sub_valid
  );
endinterface

// File: rtl/float_subtract_feeder.sv
// rtl/float_subtract_feeder.sv - pairs each dot-product result with the oldest buffered label
module float_subtract_feeder #(
  parameter int LOG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  float_subtract_feeder_if.slave bus,
  output logic [LOG_DEPTH:0]     occupancy,
  output logic [31:0]            pair_count,
  output logic                   underflow_err
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [31:0]          mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (occupancy == FULL_COUNT);
  assign empty = (occupancy == '0);
  assign push  = bus.label_valid && !full && !clear;
  // Empty is taken from the registered count, so a same-cycle push never feeds a pop.
  assign pop   = bus.dot_valid && !empty && !clear;

  assign bus.label_ready = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.label_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      pair_count    <= '0;
      underflow_err <= 1'b0;
      bus.sub_a     <= '0;
      bus.sub_b     <= '0;
      bus.sub_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      pair_count    <= '0;
      underflow_err <= 1'b0;
      bus.sub_valid <= 1'b0;
    end else begin
      bus.sub_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        bus.sub_a  <= bus.dot_in;
        bus.sub_b  <= mem[rd_ptr];
        pair_count <= pair_count + 32'd1;
      end
      if (push && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 1'b1;
      end
      if (bus.dot_valid && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end
endmodule
